umi_requester: RTL
==================

Name: umi_requester

Overview:
- Host-side UMI initiator: turns single local read/write requests into UMI request packets and collects the matching UMI response.
- Counterpart of umi_endpoint. Its uhost_req_* side drives an endpoint's udev_req_*, and its uhost_resp_* side receives the endpoint's udev_resp_*.
- At most one transaction in flight.
- Used by testbenches and small on-chip controllers that need to reach UMI devices.

Parameters:
- DW, 256, UMI data width in bits
- AW, 64, UMI address width in bits
- CW, 32, UMI command width in bits
- TIMEOUT, 1024, response timeout in cycles; used only with UMI_REQUESTER_TIMEOUT_EN

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- srcaddr_base  input  AW  this requester's UMI address; sent as srcaddr and matched against response dstaddr
- host_valid  input  1  local request valid
- host_ready  output  1  local request accepted
- host_write  input  1  1 = write, 0 = read
- host_addr  input  AW  target UMI address
- host_size  input  3  log2 bytes per word
- host_wrdata  input  DW  write data
- host_resp_valid  output  1  completion valid
- host_resp_ready  input  1  completion accepted
- host_rddata  output  DW  read data (zero for writes)
- host_err  output  1  completion error flag
- uhost_req_valid / uhost_req_ready  output / input  1  UMI request handshake
- uhost_req_cmd  output  CW  UMI request command
- uhost_req_dstaddr  output  AW  UMI request destination address
- uhost_req_srcaddr  output  AW  UMI request source address
- uhost_req_data  output  DW  UMI request data
- uhost_resp_valid / uhost_resp_ready  input / output  1  UMI response handshake
- uhost_resp_cmd  input  CW  UMI response command
- uhost_resp_dstaddr  input  AW  UMI response destination address
- uhost_resp_srcaddr  input  AW  UMI response source address
- uhost_resp_data  input  DW  UMI response data

Behaviour:
- Command encoding:
  - cmd[4:0] opcode, cmd[7:5] size, cmd[15:8] len (always 0), cmd[CW-1:16] 0.
  - Opcodes: REQ_READ=5'h01, RESP_READ=5'h02, REQ_WRITE=5'h03, RESP_WRITE=5'h04.
- FSM states: IDLE, SEND, WAIT, DONE. Reset state is IDLE.
  - IDLE:
    - host_ready=1.
    - On host_valid, latch write/addr/size/wrdata into registers, then go to SEND.
  - SEND:
    - uhost_req_valid=1 with registered fields: dstaddr=addr, srcaddr=srcaddr_base, data=wrdata for writes and 0 for reads.
    - Fields are held stable until uhost_req_ready is seen, then go to WAIT.
    - valid never drops without ready.
  - WAIT:
    - uhost_resp_ready=1.
    - A response with dstaddr != srcaddr_base is consumed and dropped; state unchanged.
    - Matching dstaddr with the expected opcode (RESP_READ for read, RESP_WRITE for write): latch host_rddata (uhost_resp_data for reads, 0 for writes), host_err=0, go to DONE.
    - Matching dstaddr with any other opcode: host_rddata=0, host_err=1, go to DONE.
  - DONE:
    - host_resp_valid=1, held until host_resp_ready, then go to IDLE.
    - host_rddata and host_err are stable while valid.
- Latency:
  - Request packet is valid 1 cycle after host acceptance.
  - Completion is valid 1 cycle after the response handshake.
  - Minimum round trip with zero-wait endpoint: 4 cycles.
- host_ready and uhost_resp_ready are 0 outside IDLE and WAIT respectively, so there is no overlap or back-to-back acceptance.
- A response arriving in IDLE, SEND or DONE is not accepted (ready=0) and waits.
- Reset values (any time, including mid-transaction): state IDLE; host_ready=1 once nreset is high; host_resp_valid, host_err, uhost_req_valid, uhost_resp_ready = 0; all data/address registers 0.

Optional Feature:
- Macro: UMI_REQUESTER_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to WAIT, increments each WAIT cycle.
  - Reaching TIMEOUT-1 without a matching response: go to DONE with host_err=1, host_rddata=0.
  - A late response is later dropped by the dstaddr/state rules.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Package umi_requester_pkg:
  - Opcode localparams.
  - Cmd field bit positions.
  - State enum typedef (IDLE/SEND/WAIT/DONE).
  - Function build_cmd(opcode, size).
- No sub-module; single FSM plus field registers.

Test Plan:
- Write then read:
  - write addr=0x10, data=0xDEAD_BEEF, size=3 -> request cmd=0x00000063, response RESP_WRITE -> completion with err=0.
  - Then read 0x10 -> host_rddata[63:0]=0xDEAD_BEEF, err=0.
- Backpressure: hold uhost_req_ready=0 for 7 cycles -> req_valid stays 1 with cmd/dstaddr/data unchanged, one packet total.
- Foreign response: in WAIT inject dstaddr=srcaddr_base+0x100 -> dropped, still WAIT; then the valid response completes normally.
- Wrong opcode: RESP_READ returned for a write -> host_resp_valid with err=1, rddata=0.
- Reset mid-operation: assert nreset low in SEND -> uhost_req_valid=0 immediately; after release, new read works.
- Timeout (with UMI_REQUESTER_TIMEOUT_EN, TIMEOUT=16): no response -> completion with err=1 exactly 16 cycles after entering WAIT.

Source files
------------

// File: rtl/umi_requester_pkg.sv
// umi_requester_pkg: UMI opcodes, command field positions, requester FSM
// state type and the command builder shared by umi_requester.
package umi_requester_pkg;

    localparam logic [4:0] REQ_READ   = 5'h01;
    localparam logic [4:0] RESP_READ  = 5'h02;
    localparam logic [4:0] REQ_WRITE  = 5'h03;
    localparam logic [4:0] RESP_WRITE = 5'h04;

    localparam int unsigned CMD_OP_LSB   = 0;
    localparam int unsigned CMD_OP_MSB   = 4;
    localparam int unsigned CMD_SIZE_LSB = 5;
    localparam int unsigned CMD_SIZE_MSB = 7;
    localparam int unsigned CMD_LEN_LSB  = 8;
    localparam int unsigned CMD_LEN_MSB  = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Low 16 bits of a single-word command; len is always zero.
    function automatic logic [15:0] build_cmd(input logic [4:0] opcode,
                                              input logic [2:0] size);
        logic [15:0] cmd;
        cmd = '0;
        cmd[CMD_OP_MSB:CMD_OP_LSB]     = opcode;
        cmd[CMD_SIZE_MSB:CMD_SIZE_LSB] = size;
        cmd[CMD_LEN_MSB:CMD_LEN_LSB]   = 8'h00;
        return cmd;
    endfunction

endpackage

// File: rtl/umi_requester.sv
// umi_requester: host-side UMI initiator with one transaction in flight.
// Latches a local request, emits one UMI request packet, waits for the
// response addressed to srcaddr_base and presents the completion locally.
// Optional macro UMI_REQUESTER_TIMEOUT_EN: abandon WAIT after TIMEOUT cycles
// with an error completion.
module umi_requester
    import umi_requester_pkg::*;
#(
    parameter int DW      = 256,
    parameter int AW      = 64,
    parameter int CW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] srcaddr_base,
    // local request / completion
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_write,
    input  logic [AW-1:0] host_addr,
    input  logic [2:0]    host_size,
    input  logic [DW-1:0] host_wrdata,
    output logic          host_resp_valid,
    input  logic          host_resp_ready,
    output logic [DW-1:0] host_rddata,
    output logic          host_err,
    // UMI request out
    output logic          uhost_req_valid,
    input  logic          uhost_req_ready,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    // UMI response in
    input  logic          uhost_resp_valid,
    output logic          uhost_resp_ready,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data
);

    state_t        state;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic [DW-1:0] wrdata_q;
    logic [4:0]    req_op;
    logic [4:0]    exp_op;
    logic [4:0]    resp_op;
    logic          resp_match;
`ifdef UMI_REQUESTER_TIMEOUT_EN
    logic [31:0]   tmo_cnt;
`endif

    assign req_op     = write_q ? REQ_WRITE : REQ_READ;
    assign exp_op     = write_q ? RESP_WRITE : RESP_READ;
    assign resp_op    = uhost_resp_cmd[CMD_OP_MSB:CMD_OP_LSB];
    assign resp_match = uhost_resp_valid && (uhost_resp_dstaddr == srcaddr_base);

    assign uhost_req_cmd     = CW'(build_cmd(req_op, size_q));
    assign uhost_req_dstaddr = addr_q;
    assign uhost_req_srcaddr = srcaddr_base;
    assign uhost_req_data    = wrdata_q;

    // Transaction FSM; every handshake output is a registered state decode.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state            <= ST_IDLE;
            write_q          <= 1'b0;
            addr_q           <= '0;
            size_q           <= '0;
            wrdata_q         <= '0;
            host_ready       <= 1'b1;
            host_resp_valid  <= 1'b0;
            host_rddata      <= '0;
            host_err         <= 1'b0;
            uhost_req_valid  <= 1'b0;
            uhost_resp_ready <= 1'b0;
`ifdef UMI_REQUESTER_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_valid) begin
                        write_q         <= host_write;
                        addr_q          <= host_addr;
                        size_q          <= host_size;
                        wrdata_q        <= host_write ? host_wrdata : '0;
                        host_ready      <= 1'b0;
                        uhost_req_valid <= 1'b1;
                        state           <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uhost_req_ready) begin
                        uhost_req_valid  <= 1'b0;
                        uhost_resp_ready <= 1'b1;
                        state            <= ST_WAIT;
`ifdef UMI_REQUESTER_TIMEOUT_EN
                        tmo_cnt          <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    // Responses for other requesters are consumed and ignored.
                    if (resp_match) begin
                        uhost_resp_ready <= 1'b0;
                        host_resp_valid  <= 1'b1;
                        state            <= ST_DONE;
                        if (resp_op == exp_op) begin
                            host_rddata <= write_q ? '0 : uhost_resp_data;
                            host_err    <= 1'b0;
                        end else begin
                            host_rddata <= '0;
                            host_err    <= 1'b1;
                        end
                    end
`ifdef UMI_REQUESTER_TIMEOUT_EN
                    else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
                        uhost_resp_ready <= 1'b0;
                        host_resp_valid  <= 1'b1;
                        host_rddata      <= '0;
                        host_err         <= 1'b1;
                        state            <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
`endif
                end
                ST_DONE: begin
                    if (host_resp_ready) begin
                        host_resp_valid <= 1'b0;
                        host_ready      <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
